// File: rtl/circuito_decodificador_sequencial_pkg.sv
// Shared line/code definitions for the seven-line encoder/decoder pair.
// Keeping the mapping here means both ends agree on which bit is which line.
package circuito_decodificador_sequencial_pkg;

    localparam int NUM_LINES = 7;
    localparam int CODE_W    = 3;

    // FSM state encoding shared by the encoder/decoder blocks
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HOLD = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    // Code n (1..7) maps to line bit n-1; code 0 selects no line.
    function automatic logic [NUM_LINES-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [NUM_LINES-1:0] result;
        result = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (code == CODE_W'(i + 1)) begin
                result[i] = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/circuito_decodificador_sequencial.sv
// Registered 3-to-7 decoder: restores one of seven lines (A..G) from a binary
// code, holds it for HOLD_CYCLES, then keeps all lines low for GAP_CYCLES.
//
// Handshake: a code transfers on a rising edge where code_valid_i and
// code_ready_o are both high. code_ready_o depends only on the state register
// (high in IDLE), never on code_valid_i. While busy, code_valid_i is ignored
// and the source is expected to hold its code until ready returns.
module circuito_decodificador_sequencial
    import circuito_decodificador_sequencial_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CODE_W-1:0]    code_i,
    input  logic                 code_valid_i,
    output logic                 code_ready_o,
    output logic [NUM_LINES-1:0] line_o,
    output logic                 busy_o,
    output logic                 err_o
);

    // One counter serves both the hold and gap phases, so it is sized for the
    // longer of the two (and at least one bit).
    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES)
                           ? ((HOLD_CYCLES > 2) ? HOLD_CYCLES : 2)
                           : ((GAP_CYCLES  > 2) ? GAP_CYCLES  : 2);
    localparam int CNT_W   = $clog2(MAX_CNT);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Ready and busy come straight from the state register: no input-to-output path.
    assign code_ready_o = (state == ST_IDLE);
    assign busy_o       = (state != ST_IDLE);

    // FSM, phase counter and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            line_o <= '0;
            err_o  <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (code_valid_i) begin
                        if (code_i != '0) begin
                            line_o <= onehot(code_i);
                            cnt    <= HOLD_LOAD;
                            state  <= ST_HOLD;
                        end else begin
                            // Code 0 has no line: flag it and stay ready.
                            err_o <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        line_o <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt   <= GAP_LOAD;
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    line_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_circuito_decodificador_sequencial.sv
// Bench for the sequential 3-to-7 decoder: directed scenarios plus random codes
// on a HOLD=4/GAP=1 instance, and a back-to-back run on a HOLD=4/GAP=0 instance.
module tb_circuito_decodificador_sequencial;

    localparam int HOLD = 4;
    localparam int GAP  = 1;
    localparam int W    = 8;   // {err, line[6:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // main instance (GAP = 1)
    logic [2:0] code;
    logic       valid;
    logic       code_ready_o, busy_o, err_o;
    logic [6:0] line_o;

    // back-to-back instance (GAP = 0)
    logic [2:0] code_b;
    logic       valid_b;
    logic       ready_b, busy_b, err_b;
    logic [6:0] line_b;

    circuito_decodificador_sequencial #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .code_i(code), .code_valid_i(valid),
        .code_ready_o(code_ready_o), .line_o(line_o), .busy_o(busy_o), .err_o(err_o)
    );

    circuito_decodificador_sequencial #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .code_i(code_b), .code_valid_i(valid_b),
        .code_ready_o(ready_b), .line_o(line_b), .busy_o(busy_b), .err_o(err_b)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference line pattern: code n lights bit n-1, code 0 lights nothing.
    function automatic logic [6:0] model_line(input int c);
        logic [6:0] one;
        one = 7'd1;
        return (c == 0) ? 7'd0 : 7'(one << (c - 1));
    endfunction

    // ---------------- monitor ----------------
    logic [6:0]   prev_line = '0;
    int           run = 0;
    int           gap = 0;
    bit           in_gap = 0;
    logic [W-1:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_line = '0;
            run = 0;
            gap = 0;
            in_gap = 0;
        end else begin
            check("ready_is_not_busy", code_ready_o, !busy_o);
            check("at_most_one_line", ($countones(line_o) > 1), 0);
            if (line_o != '0) check("busy_during_hold", busy_o, 1'b1);
            if (err_o || (line_o != '0 && prev_line == '0)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {err_o, line_o}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("output_value", {err_o, line_o}, e);
                end
            end
            if (line_o != '0) begin
                if (prev_line != '0) check("line_stable_in_hold", line_o, prev_line);
                run++;
            end else if (prev_line != '0) begin
                check("hold_length", run, HOLD);
                run = 0;
                in_gap = 1;
                gap = 0;
            end
            if (in_gap) begin
                if (busy_o && line_o == '0) gap++;
                else begin
                    check("gap_length", gap, GAP);
                    in_gap = 0;
                end
            end
            prev_line = line_o;
        end
    end

    // ---------------- driver tasks ----------------
    // Called away from clock edges; returns just after the negedge following transfer.
    task automatic send(input int c);
        int waited;
        waited = 0;
        code  = 3'(c);
        valid = 1'b1;
        while (!code_ready_o && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!code_ready_o) begin
            check("ready_timeout", 0, 1);
            valid = 1'b0;
            return;
        end
        exp_q.push_back((c == 0) ? 8'h80 : {1'b0, model_line(c)});
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        if (c == 0) check("err_latency", err_o, 1'b1);
        else        check("line_latency", line_o, model_line(c));
    endtask

    // Drop reset between edges and confirm outputs change without a clock.
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_line"},  line_o, 0);
        check({tag, "_err"},   err_o, 0);
        check({tag, "_busy"},  busy_o, 0);
        check({tag, "_ready"}, code_ready_o, 1);
        check({tag, "_line_b"}, line_b, 0);
        check({tag, "_ready_b"}, ready_b, 1);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, slot, pos;
        logic [6:0] exp_b;
        code = '0; valid = 1'b0; code_b = '0; valid_b = 1'b0;

        // power-on reset, checked before the first clock edge
        rst_n = 1'b0;
        #3;
        check("por_line", line_o, 0);
        check("por_err", err_o, 0);
        check("por_busy", busy_o, 0);
        check("por_ready", code_ready_o, 1);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);

        // basic hold/gap with code 3
        send(3);
        // valid stays high across the hold with code 5, then 6; only 6 transfers
        code = 3'd5; valid = 1'b1;
        repeat (2) @(negedge clk);
        check("held_line_ignores_code", line_o, model_line(3));
        send(6);

        // code 0 then code 7 on the very next edge
        send(0);
        send(7);

        // reset during GAP, then during HOLD
        send(2);
        repeat (HOLD) @(posedge clk);
        #2 pulse_reset("rst_gap");
        @(negedge clk);
        send(4);
        @(posedge clk);
        #2 pulse_reset("rst_hold");
        @(negedge clk);
        send(1);

        // random codes with random idle spacing
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send($urandom_range(0, 7));
        end
        repeat (HOLD + GAP + 4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        // back-to-back 1..7 on the GAP=0 instance, valid always high
        @(negedge clk);
        code_b = 3'd1; valid_b = 1'b1;
        @(posedge clk);
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            slot = n / (HOLD + 1);
            pos  = n % (HOLD + 1);
            exp_b = (slot < 7 && pos < HOLD) ? model_line(slot + 1) : 7'd0;
            check("b2b_line", line_b, exp_b);
            check("b2b_single_bit", ($countones(line_b) > 1), 0);
            if (n < 35) check("b2b_ready", ready_b, (pos == HOLD));
            check("b2b_err", err_b, 0);
            if (slot + 2 > 7) valid_b = 1'b0;
            else              code_b = 3'(slot + 2);
        end
        check("b2b_idle", busy_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // overall time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/circuito_decodificador_sequencial.md
# circuito_decodificador_sequencial

Registered 3-bit-to-7-line decoder: the receiving end of the seven-input priority-free encoder path. It accepts a binary code (1..7) over a valid/ready handshake and drives exactly one of seven one-hot lines for a programmable hold time, followed by a programmable quiet gap. Code 0 carries no line and is flagged as an error. It sits downstream of the encoder, restoring the selected line (A..G) for actuator/display logic.

## Interface
- HOLD_CYCLES, 4, cycles a selected line stays asserted; legal range ≥1
- GAP_CYCLES, 1, all-lines-low cycles after a hold before the next code is accepted; legal range ≥0
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- code_i  in  3  binary code; 1..7 select a line, 0 is invalid
- code_valid_i  in  1  code_i is presented
- code_ready_o  out  1  block can accept a code this cycle
- line_o  out  7  one-hot output; bit n-1 = code n (bit 6 = A … bit 0 = G for code 7 … 1)
- busy_o  out  1  high in HOLD or GAP
- err_o  out  1  one-cycle pulse: code 0 was accepted

## Operation
- States: IDLE, HOLD, GAP; one down-counter cnt, width clog2(max(HOLD_CYCLES,GAP_CYCLES,2)).
- Transfer occurs on a rising edge where code_valid_i && code_ready_o.
- code_ready_o = (state == IDLE); combinational from state register only, never from code_valid_i.
- IDLE, transfer with code_i ≠ 0: line_o ← onehot(code_i), cnt ← HOLD_CYCLES−1, → HOLD.
- IDLE, transfer with code_i = 0: err_o ← 1 for the next cycle, line_o stays 0, remain IDLE.
- HOLD: cnt ≠ 0 → cnt−1; cnt = 0 → line_o ← 0; if GAP_CYCLES = 0 → IDLE, else cnt ← GAP_CYCLES−1, → GAP.
- GAP: cnt ≠ 0 → cnt−1; cnt = 0 → IDLE.
- code_valid_i in HOLD/GAP is ignored (no transfer, no side effect); the source holds the code until ready.
- code_i is sampled only at transfer; later changes during HOLD do not alter line_o.
- line_o is always 0 or exactly one-hot; never more than one bit.
- busy_o = (state ≠ IDLE).

## Timing
- Reset (async, rst_n low): state IDLE, cnt 0, line_o 0000000, err_o 0, busy_o 0, code_ready_o 1 (ready is high during reset); all take effect immediately, without waiting for clk.
- Reset asserted mid-HOLD/GAP: line_o drops to 0 immediately; the in-flight code is lost.
- Transfer at edge k (code ≠ 0): line_o valid from edge k through edge k+HOLD_CYCLES, i.e. exactly HOLD_CYCLES cycles; latency one edge from transfer.
- line_o low, busy_o high for GAP_CYCLES cycles after edge k+HOLD_CYCLES; code_ready_o high after edge k+HOLD_CYCLES+GAP_CYCLES.
- Earliest next transfer at edge k+HOLD_CYCLES+GAP_CYCLES+1; sustained period HOLD_CYCLES+GAP_CYCLES+1.
- Code 0 transfer at edge k: err_o high for cycle k..k+1 only; ready stays high, so a new code may transfer at edge k+1.
- No combinational path from any input to any output.

## Structure
- Shared package (with encoder): NUM_LINES = 7, CODE_W = 3, state enum {IDLE, HOLD, GAP}, function onehot(code) returning 7 bits (0 for code 0).
- No sub-module; counter and FSM are in one module. The encoder and decoder share the package so that the line/code mapping is defined once.

## Test plan
- Reset: rst_n low mid-cycle → line_o=0, err_o=0, busy_o=0, code_ready_o=1 without a clock edge.
- HOLD=4, GAP=1, code 3 at edge k → line_o=0000100 for edges k..k+4, 0 thereafter, busy_o high edges k..k+5, ready back after edge k+5.
- Valid held high with code 5 during HOLD of code 3, code changed to 6 mid-hold → line_o stays 0000100; code 5/6 are accepted only when ready returns.
- Code 0 accepted → err_o single-cycle pulse, line_o 0, code 7 accepted next edge → line_o=1000000.
- Back-to-back codes 1..7 with valid always high, GAP=0 → each line asserted 4 cycles, period 5, never two bits high.
- rst_n pulsed low during GAP then during HOLD → outputs reset asynchronously; first transfer after release behaves as from IDLE.
